// File: rtl/mnist_pkg.sv
// Shared constants and window bit-layout helper for the conv2 stage of the MNIST pipeline.
package mnist_pkg;

    localparam int IMG_WIDTH  = 13;
    localparam int IMG_HEIGHT = 13;
    localparam int NUM_CH     = 8;
    localparam int WIN_W      = NUM_CH * 9;

    // Flat bit position of window element (channel, window row, window column).
    function automatic int win_bit(input int c, input int wr, input int wc);
        return 9 * c + 3 * wr + wc;
    endfunction

endpackage

// File: rtl/conv2_row_delay.sv
// One-row delay line: o_dout is the word written DEPTH enabled cycles ago.
module conv2_row_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 13
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are left unreset; the window row gating never lets stale data reach the output.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/conv2_window_buf.sv
// 3x3 x NUM_CH sliding-window former feeding the conv2 calculator (no padding, 11x11 windows).
// Optional frame_done output enabled by defining CONV2_BUF_FRAME_DONE_EN.
module conv2_window_buf
    import mnist_pkg::*;
#(
    parameter int IMG_WIDTH  = mnist_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = mnist_pkg::IMG_HEIGHT,
    parameter int NUM_CH     = mnist_pkg::NUM_CH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic                  sof_in,
    input  logic [NUM_CH-1:0]     pixel_in,
    output logic [NUM_CH*9-1:0]   pixel_windows,
`ifdef CONV2_BUF_FRAME_DONE_EN
    output logic                  frame_done,
`endif
    output logic                  valid_out_buf
);

    localparam int WIN_BITS = NUM_CH * 9;
    localparam int COL_W    = $clog2(IMG_WIDTH);
    localparam int ROW_W    = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [WIN_BITS-1:0] r_win;

    logic [COL_W-1:0]    w_pos_col;
    logic [ROW_W-1:0]    w_pos_row;
    logic [COL_W-1:0]    w_nxt_col;
    logic [ROW_W-1:0]    w_nxt_row;
    logic                w_col_wrap;
    logic                w_emit;
    logic                w_last;
    logic [NUM_CH-1:0]   w_row1_out;
    logic [NUM_CH-1:0]   w_row2_out;
    logic [WIN_BITS-1:0] w_win_nxt;

    conv2_row_delay #(.WIDTH(NUM_CH), .DEPTH(IMG_WIDTH)) u_row1 (
        .clk    (clk),
        .i_en   (valid_in),
        .i_din  (pixel_in),
        .o_dout (w_row1_out)
    );

    conv2_row_delay #(.WIDTH(NUM_CH), .DEPTH(IMG_WIDTH)) u_row2 (
        .clk    (clk),
        .i_en   (valid_in),
        .i_din  (w_row1_out),
        .o_dout (w_row2_out)
    );

    // sof_in forces the current pixel to (0,0) whatever the counters say.
    always_comb begin
        w_pos_col  = sof_in ? '0 : r_col;
        w_pos_row  = sof_in ? '0 : r_row;
        w_col_wrap = (w_pos_col == COL_W'(IMG_WIDTH - 1));
        w_nxt_col  = w_col_wrap ? '0 : w_pos_col + COL_W'(1);
        w_nxt_row  = w_pos_row;
        if (w_col_wrap) begin
            w_nxt_row = (w_pos_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : w_pos_row + ROW_W'(1);
        end
        w_emit = valid_in && (w_pos_row >= ROW_W'(2)) && (w_pos_col >= COL_W'(2));
        w_last = w_col_wrap && (w_pos_row == ROW_W'(IMG_HEIGHT - 1));
    end

    always_comb begin
        w_win_nxt = r_win;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int wr = 0; wr < 3; wr++) begin
                w_win_nxt[win_bit(c, wr, 0)] = r_win[win_bit(c, wr, 1)];
                w_win_nxt[win_bit(c, wr, 1)] = r_win[win_bit(c, wr, 2)];
            end
            w_win_nxt[win_bit(c, 0, 2)] = w_row2_out[c];
            w_win_nxt[win_bit(c, 1, 2)] = w_row1_out[c];
            w_win_nxt[win_bit(c, 2, 2)] = pixel_in[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col         <= '0;
            r_row         <= '0;
            r_win         <= '0;
            pixel_windows <= '0;
            valid_out_buf <= 1'b0;
        end else begin
            valid_out_buf <= w_emit;
            if (valid_in) begin
                r_col <= w_nxt_col;
                r_row <= w_nxt_row;
                r_win <= w_win_nxt;
            end
            if (w_emit) begin
                pixel_windows <= w_win_nxt;
            end
        end
    end

`ifdef CONV2_BUF_FRAME_DONE_EN
    // Only the bottom-right window of an uninterrupted frame reaches w_last with w_emit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_emit && w_last;
        end
    end
`endif

endmodule

// File: tb/tb_conv2_window_buf.sv
// Directed bench for conv2_window_buf: full frames, hot pixel, gaps, sof restart, async reset.
module tb_conv2_window_buf;
    import mnist_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        sof_in;
    logic [7:0]  pixel_in;
    logic [71:0] pixel_windows;
    logic        valid_out_buf;
`ifdef CONV2_BUF_FRAME_DONE_EN
    logic        frame_done;
`endif

    conv2_window_buf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .sof_in        (sof_in),
        .pixel_in      (pixel_in),
        .pixel_windows (pixel_windows),
`ifdef CONV2_BUF_FRAME_DONE_EN
        .frame_done    (frame_done),
`endif
        .valid_out_buf (valid_out_buf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  img [0:12][0:12];
    logic [71:0] capq[$];
    int          acc_cnt;
    int          first_acc;
    int          b2b;
    bit          prev_v;
    int          fd_at[$];
    int          fd_bad;

    always @(posedge clk) begin
        if (valid_in) acc_cnt++;
    end

    always @(negedge clk) begin
        if (valid_out_buf) begin
            capq.push_back(pixel_windows);
            if (first_acc < 0) first_acc = acc_cnt;
            if (prev_v) b2b++;
        end
        prev_v = valid_out_buf;
`ifdef CONV2_BUF_FRAME_DONE_EN
        if (frame_done) begin
            fd_at.push_back(capq.size());
            if (!valid_out_buf) fd_bad++;
        end
`endif
    end

    function automatic logic [71:0] exp_win(input int tr, input int tc);
        logic [71:0] w;
        w = '0;
        for (int c = 0; c < 8; c++)
            for (int wr = 0; wr < 3; wr++)
                for (int wc = 0; wc < 3; wc++)
                    w[win_bit(c, wr, wc)] = img[tr+wr][tc+wc][c];
        return w;
    endfunction

    task automatic set_frame(input int kind);
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 13; c++)
                img[r][c] = (kind == 1) ? 8'hFF : 8'h00;
        if (kind == 2) img[6][6] = 8'h08;
    endtask

    task automatic clear_cap();
        capq.delete();
        fd_at.delete();
        acc_cnt   = 0;
        first_acc = -1;
        b2b       = 0;
        prev_v    = 1'b0;
        fd_bad    = 0;
    endtask

    task automatic send_pixel(input bit v, input bit s, input logic [7:0] p);
        @(posedge clk);
        #1;
        valid_in = v;
        sof_in   = s;
        pixel_in = p;
    endtask

    task automatic idle(input int n);
        repeat (n) send_pixel(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int npix, input bit sof, input bit gaps);
        for (int i = 0; i < npix; i++) begin
            send_pixel(1'b1, sof && (i == 0), img[i / 13][i % 13]);
            if (gaps) send_pixel(1'b0, 1'b1, 8'hA5);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_in = 1'b0; sof_in = 1'b0; pixel_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pixel_windows !== 72'h0) begin
            errors++; $display("FAIL reset_windows got=%h want=0", pixel_windows);
        end
        checks++;
        if (valid_out_buf !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b want=0", valid_out_buf);
        end
`ifdef CONV2_BUF_FRAME_DONE_EN
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done got=%b want=0", frame_done);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_all_ones();
        clear_cap();
        set_frame(1);
        send_frame(169, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (first_acc !== 29) begin
            errors++; $display("FAIL ones_first_strobe got=%0d want=29 accepted pixels", first_acc);
        end
        checks++;
        if (capq.size() !== 121) begin
            errors++; $display("FAIL ones_count got=%0d want=121", capq.size());
        end
        for (int k = 0; k < capq.size(); k++) begin
            checks++;
            if (capq[k] !== 72'hFF_FFFF_FFFF_FFFF_FFFF) begin
                errors++; $display("FAIL ones_win%0d got=%h want=all ones", k, capq[k]);
            end
        end
    endtask

    task automatic test_hot_pixel();
        int nz;
        logic [71:0] ref44;
        logic [71:0] ref66;
        ref44 = 72'h0; ref44[35] = 1'b1;
        ref66 = 72'h0; ref66[27] = 1'b1;
        clear_cap();
        set_frame(2);
        send_frame(169, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (capq.size() !== 121) begin
            errors++; $display("FAIL hot_count got=%0d want=121", capq.size());
        end else begin
            nz = 0;
            for (int k = 0; k < 121; k++) if (capq[k] != 72'h0) nz++;
            checks++;
            if (nz !== 9) begin
                errors++; $display("FAIL hot_nonzero got=%0d want=9", nz);
            end
            checks++;
            if (capq[4*11+4] !== ref44) begin
                errors++; $display("FAIL hot_win44 got=%h want=%h", capq[48], ref44);
            end
            checks++;
            if (capq[6*11+6] !== ref66) begin
                errors++; $display("FAIL hot_win66 got=%h want=%h", capq[72], ref66);
            end
            for (int k = 0; k < 121; k++) begin
                checks++;
                if (capq[k] !== exp_win(k / 11, k % 11)) begin
                    errors++; $display("FAIL hot_win%0d got=%h want=%h", k, capq[k], exp_win(k / 11, k % 11));
                end
            end
        end
    endtask

    task automatic test_gaps();
        clear_cap();
        set_frame(2);
        send_frame(169, 1'b1, 1'b1);
        idle(3);
        checks++;
        if (b2b !== 0) begin
            errors++; $display("FAIL gaps_back_to_back got=%0d want=0", b2b);
        end
        checks++;
        if (capq.size() !== 121) begin
            errors++; $display("FAIL gaps_count got=%0d want=121", capq.size());
        end else begin
            for (int k = 0; k < 121; k++) begin
                checks++;
                if (capq[k] !== exp_win(k / 11, k % 11)) begin
                    errors++; $display("FAIL gaps_win%0d got=%h want=%h", k, capq[k], exp_win(k / 11, k % 11));
                end
            end
        end
    endtask

    task automatic test_sof_restart();
        clear_cap();
        set_frame(1);
        send_frame(50, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (capq.size() !== 20) begin
            errors++; $display("FAIL sof_old_count got=%0d want=20", capq.size());
        end
        clear_cap();
        set_frame(2);
        send_frame(169, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (first_acc !== 29) begin
            errors++; $display("FAIL sof_first_strobe got=%0d want=29 accepted pixels", first_acc);
        end
        checks++;
        if (capq.size() !== 121) begin
            errors++; $display("FAIL sof_count got=%0d want=121", capq.size());
        end else begin
            for (int k = 0; k < 121; k++) begin
                checks++;
                if (capq[k] !== exp_win(k / 11, k % 11)) begin
                    errors++; $display("FAIL sof_win%0d got=%h want=%h", k, capq[k], exp_win(k / 11, k % 11));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_cap();
        set_frame(1);
        send_frame(81, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        #2;
        checks++;
        if (valid_out_buf !== 1'b1 || pixel_windows !== 72'hFF_FFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL rstmid_before got=%b/%h want=1/all ones", valid_out_buf, pixel_windows);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out_buf !== 1'b0) begin
            errors++; $display("FAIL rstmid_valid got=%b want=0", valid_out_buf);
        end
        checks++;
        if (pixel_windows !== 72'h0) begin
            errors++; $display("FAIL rstmid_windows got=%h want=0", pixel_windows);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_cap();
        set_frame(2);
        send_frame(169, 1'b0, 1'b0);
        idle(3);
        checks++;
        if (capq.size() !== 121) begin
            errors++; $display("FAIL rstmid_count got=%0d want=121", capq.size());
        end else begin
            for (int k = 0; k < 121; k++) begin
                checks++;
                if (capq[k] !== exp_win(k / 11, k % 11)) begin
                    errors++; $display("FAIL rstmid_win%0d got=%h want=%h", k, capq[k], exp_win(k / 11, k % 11));
                end
            end
        end
    endtask

`ifdef CONV2_BUF_FRAME_DONE_EN
    task automatic test_frame_done();
        clear_cap();
        set_frame(1);
        send_frame(169, 1'b1, 1'b0);
        send_frame(169, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (fd_at.size() !== 2) begin
            errors++; $display("FAIL fd_pulses got=%0d want=2", fd_at.size());
        end else begin
            checks++;
            if (fd_at[0] !== 121 || fd_at[1] !== 242) begin
                errors++; $display("FAIL fd_align got=%0d,%0d want=121,242", fd_at[0], fd_at[1]);
            end
        end
        clear_cap();
        send_frame(160, 1'b1, 1'b0);
        send_frame(169, 1'b1, 1'b0);
        idle(3);
        checks++;
        if (fd_at.size() !== 1) begin
            errors++; $display("FAIL fd_trunc_pulses got=%0d want=1", fd_at.size());
        end else begin
            checks++;
            if (fd_at[0] !== 233) begin
                errors++; $display("FAIL fd_trunc_align got=%0d want=233", fd_at[0]);
            end
        end
        checks++;
        if (fd_bad !== 0) begin
            errors++; $display("FAIL fd_without_valid got=%0d want=0", fd_bad);
        end
    endtask
`endif

    initial begin
        clear_cap();
        test_reset();
        test_all_ones();
        test_hot_pixel();
        test_gaps();
        test_sof_restart();
        test_reset_mid();
`ifdef CONV2_BUF_FRAME_DONE_EN
        test_frame_done();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
